// File: rtl/pc_unit.sv
// Program counter with sequential increment/load and a fixed-latency
// conditional-branch path (IDLE -> WAIT -> RESOLVE) that adds a signed 19-bit displacement.
module pc_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic        PCin,
    input  logic        IncPC,
    input  logic        BrEval,
    input  logic        Stall,
    input  logic [31:0] BusMuxOut,
    input  logic [31:0] IR,
    input  logic        branch,
    output logic [31:0] PC,
    output logic        BrTaken,
    output logic        Busy
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DISP_W = 19;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              br_taken_q, br_taken_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   disp;
    logic              unused_ir;

    // Only IR[18:0] carries the displacement; the opcode/register fields are not used here.
    assign unused_ir = ^IR[XLEN-1:DISP_W];
    assign disp      = {{(XLEN-DISP_W){IR[DISP_W-1]}}, IR[DISP_W-1:0]};

    // Next-state: Stall freezes everything; requests are only honoured in IDLE.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        br_taken_d = 1'b0;
        if (!Stall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (BrEval) begin
                        state_d = S_WAIT;
                    end else if (PCin) begin
                        pc_d = BusMuxOut;
                    end else if (IncPC) begin
                        pc_d = pc_q + XLEN'(1);
                    end
                end
                S_WAIT: begin
                    state_d = S_RESOLVE;
                end
                S_RESOLVE: begin
                    state_d = S_IDLE;
                    if (branch) begin
                        pc_d       = pc_q + disp;
                        br_taken_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            br_taken_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            br_taken_q <= br_taken_d;
            busy_q     <= busy_d;
        end
    end

    assign PC      = pc_q;
    assign BrTaken = br_taken_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: increment, load, branch taken/not-taken,
// stall during resolution, reset abort and 32-bit wrap.
module tb_pc_unit;

    logic        clock;
    logic        clear;
    logic        PCin;
    logic        IncPC;
    logic        BrEval;
    logic        Stall;
    logic [31:0] BusMuxOut;
    logic [31:0] IR;
    logic        branch;
    logic [31:0] PC;
    logic        BrTaken;
    logic        Busy;

    int vectors;
    int miscompares;

    pc_unit dut (
        .clock     (clock),
        .clear     (clear),
        .PCin      (PCin),
        .IncPC     (IncPC),
        .BrEval    (BrEval),
        .Stall     (Stall),
        .BusMuxOut (BusMuxOut),
        .IR        (IR),
        .branch    (branch),
        .PC        (PC),
        .BrTaken   (BrTaken),
        .Busy      (Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        PCin = 1'b0; IncPC = 1'b0; BrEval = 1'b0; Stall = 1'b0;
        BusMuxOut = 32'h0; IR = 32'h0; branch = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        PCin = 1'b1; BusMuxOut = v;
        step();
        PCin = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clear = 1'b0;
        #12;
        vectors++;
        if (PC !== 32'h0 || Busy !== 1'b0 || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: PC=%h Busy=%b BrTaken=%b, want 0/0/0", PC, Busy, BrTaken);
        end
        @(negedge clock);
        clear = 1'b1;
        step();
        vectors++;
        if (PC !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_idle: PC=%h, want 0", PC);
        end
    endtask

    task automatic test_increment();
        IncPC = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if (PC !== 32'(i) || Busy !== 1'b0) begin
                miscompares++;
                $display("FAIL inc%0d: PC=%h Busy=%b, want %h/0", i, PC, Busy, 32'(i));
            end
        end
        IncPC = 1'b0;
    endtask

    // Runs one branch from a known PC; checks every cycle of the fixed latency.
    task automatic run_branch(input string name, input logic [31:0] start, input logic [31:0] ir_v,
                              input logic br, input logic [31:0] exp_pc);
        load_pc(start);
        BrEval = 1'b1; IR = 32'hFFFF_FFFF; branch = ~br;
        step();
        BrEval = 1'b0;
        vectors++;
        if (PC !== start || Busy !== 1'b1 || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_wait: PC=%h Busy=%b BrTaken=%b, want %h/1/0", name, PC, Busy, BrTaken, start);
        end
        PCin = 1'b1; IncPC = 1'b1; BusMuxOut = 32'hDEAD_0000;
        step();
        PCin = 1'b0; IncPC = 1'b0;
        vectors++;
        if (PC !== start || Busy !== 1'b1 || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_resolve: PC=%h Busy=%b BrTaken=%b, want %h/1/0", name, PC, Busy, BrTaken, start);
        end
        IR = ir_v; branch = br;
        step();
        IR = 32'h0; branch = 1'b0;
        vectors++;
        if (PC !== exp_pc || Busy !== 1'b0 || BrTaken !== br) begin
            miscompares++;
            $display("FAIL %s_done: PC=%h Busy=%b BrTaken=%b, want %h/0/%b", name, PC, Busy, BrTaken, exp_pc, br);
        end
        step();
        vectors++;
        if (PC !== exp_pc || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after: PC=%h BrTaken=%b, want %h/0", name, PC, BrTaken, exp_pc);
        end
    endtask

    task automatic test_branch();
        run_branch("br_pos", 32'h10, 32'hABC0_0005, 1'b1, 32'h15);
        run_branch("br_neg", 32'h10, 32'h0007_FFFC, 1'b1, 32'h0C);
        run_branch("br_not", 32'h10, 32'h0007_FFFC, 1'b0, 32'h10);
        run_branch("br_wrap", 32'h2, 32'h0007_FFFC, 1'b1, 32'hFFFF_FFFE);
    endtask

    task automatic test_priority();
        PCin = 1'b1; IncPC = 1'b1; BusMuxOut = 32'h200;
        step();
        PCin = 1'b0; IncPC = 1'b0;
        vectors++;
        if (PC !== 32'h200) begin
            miscompares++;
            $display("FAIL pcin_over_inc: PC=%h, want 00000200", PC);
        end
        BrEval = 1'b1; PCin = 1'b1; IncPC = 1'b1; BusMuxOut = 32'h999;
        step();
        BrEval = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        vectors++;
        if (PC !== 32'h200 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL breval_first: PC=%h Busy=%b, want 00000200/1", PC, Busy);
        end
        step();
        step();
        vectors++;
        if (PC !== 32'h200 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL breval_nottaken: PC=%h Busy=%b, want 00000200/0", PC, Busy);
        end
    endtask

    task automatic test_stall();
        load_pc(32'h10);
        BrEval = 1'b1;
        step();
        BrEval = 1'b0;
        Stall = 1'b1; IncPC = 1'b1;
        step();
        step();
        vectors++;
        if (PC !== 32'h10 || Busy !== 1'b1 || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold: PC=%h Busy=%b BrTaken=%b, want 00000010/1/0", PC, Busy, BrTaken);
        end
        Stall = 1'b0; IncPC = 1'b0;
        step();
        vectors++;
        if (PC !== 32'h10 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_resolve: PC=%h Busy=%b, want 00000010/1", PC, Busy);
        end
        IR = 32'h5; branch = 1'b1;
        step();
        branch = 1'b0;
        vectors++;
        if (PC !== 32'h15 || Busy !== 1'b0 || BrTaken !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done: PC=%h Busy=%b BrTaken=%b, want 00000015/0/1", PC, Busy, BrTaken);
        end
        Stall = 1'b1; IncPC = 1'b1;
        step();
        vectors++;
        if (PC !== 32'h15 || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle: PC=%h BrTaken=%b, want 00000015/0", PC, BrTaken);
        end
        Stall = 1'b0; IncPC = 1'b0;
    endtask

    task automatic test_clear_abort();
        load_pc(32'h40);
        BrEval = 1'b1;
        step();
        BrEval = 1'b0;
        step();
        IR = 32'h5; branch = 1'b1;
        #2;
        clear = 1'b0;
        #1;
        vectors++;
        if (PC !== 32'h0 || Busy !== 1'b0 || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_abort: PC=%h Busy=%b BrTaken=%b, want 0/0/0", PC, Busy, BrTaken);
        end
        @(negedge clock);
        clear = 1'b1;
        step();
        vectors++;
        if (PC !== 32'h0 || Busy !== 1'b0 || BrTaken !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_after: PC=%h Busy=%b BrTaken=%b, want 0/0/0", PC, Busy, BrTaken);
        end
        branch = 1'b0; IR = 32'h0;
    endtask

    task automatic test_wrap();
        load_pc(32'hFFFF_FFFF);
        IncPC = 1'b1;
        step();
        IncPC = 1'b0;
        vectors++;
        if (PC !== 32'h0) begin
            miscompares++;
            $display("FAIL inc_wrap: PC=%h, want 00000000", PC);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_increment();
        test_branch();
        test_priority();
        test_stall();
        test_clear_abort();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL expose: clock  input  1  single system clock; all state updates on rising edge.
REQ-002 The block SHALL expose: clear  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL expose: PCin  input  1  load PC from BusMuxOut.
REQ-004 The block SHALL expose: IncPC  input  1  increment PC by one word.
REQ-005 The block SHALL expose: BrEval  input  1  start conditional-branch resolution.
REQ-006 The block SHALL expose: Stall  input  1  freeze all state.
REQ-007 The block SHALL expose: BusMuxOut  input  32  bus value for PCin loads.
REQ-008 The block SHALL expose: IR  input  32  current instruction; IR[18:0] is the branch displacement C.
REQ-009 The block SHALL expose: branch  input  1  branch-condition flag from the CON FF stage.
REQ-010 The block SHALL expose: PC  output  32  current program counter.
REQ-011 The block SHALL expose: BrTaken  output  1  one-cycle pulse when a branch is applied.
REQ-012 The block SHALL expose: Busy  output  1  high while branch resolution is in progress.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT, RESOLVE.
REQ-014 In IDLE with Stall=0, BrEval=1 SHALL move the FSM to WAIT; PC SHALL be unchanged that cycle.
REQ-015 WAIT SHALL last exactly one cycle and then go to RESOLVE; this gives the CON FF one edge to capture the condition.
REQ-016 In RESOLVE with branch=1, PC SHALL become PC + sign_extend(IR[18:0]) and BrTaken SHALL be 1 for that single cycle.
REQ-017 In RESOLVE with branch=0, PC SHALL be unchanged and BrTaken SHALL stay 0.
REQ-018 The FSM SHALL return to IDLE after RESOLVE in every case.
REQ-019 Branch latency SHALL be fixed: BrEval sampled at edge N, PC update visible after edge N+2.
REQ-020 Busy SHALL be 1 in WAIT and RESOLVE and 0 in IDLE.
REQ-021 BrTaken SHALL be registered and SHALL be 0 in all other cycles.
REQ-022 In IDLE with Stall=0 and BrEval=0: PCin=1 SHALL load PC from BusMuxOut; otherwise IncPC=1 SHALL set PC to PC+1.
REQ-023 Priority in IDLE SHALL be BrEval > PCin > IncPC.
REQ-024 PCin, IncPC and BrEval SHALL be ignored while Busy=1.
REQ-025 Stall=1 SHALL hold PC, FSM state and BrTaken (BrTaken forced to 0) at any state; resolution continues when Stall returns to 0.
REQ-026 All arithmetic SHALL be modulo 2^32: 0xFFFFFFFF+1 gives 0x00000000, and a negative displacement below 0 wraps.
REQ-027 IR and branch SHALL be sampled only in RESOLVE; changes in other states SHALL have no effect.

Reset
REQ-028 When clear=0, PC SHALL go to 0x00000000, the FSM to IDLE, and BrTaken and Busy to 0, immediately and asynchronously.
REQ-029 clear=0 during WAIT or RESOLVE SHALL abort resolution with no PC update.
REQ-030 After clear is released, the first rising edge SHALL be a normal IDLE cycle.

Verification
REQ-031 Reset, then IncPC=1 for 3 cycles -> PC = 0x00000003; Busy = 0 throughout.
REQ-032 PC=0x10, IR[18:0]=0x00005, BrEval pulse, branch=1 at RESOLVE -> PC = 0x15 two edges after BrEval; BrTaken high for exactly one cycle.
REQ-033 PC=0x10, IR[18:0]=0x7FFFC (-4), branch=1 -> PC = 0x0C; same flow with branch=0 -> PC = 0x10 and BrTaken never asserts.
REQ-034 PCin=1 with IncPC=1 and BusMuxOut=0x200 -> PC = 0x200; PCin/IncPC asserted during WAIT -> PC unchanged.
REQ-035 Stall=1 held 2 cycles while in WAIT -> resolution completes 2 cycles late with the correct PC.
REQ-036 clear=0 pulsed in RESOLVE -> PC = 0, Busy = 0, no BrTaken; PC = 0xFFFFFFFF with IncPC -> PC = 0.
